// File: rtl/bsg_mem_nr1w_sync.sv
// bsg_mem_nr1w_sync: one write port, read_ports_p synchronous read ports.
// Define BSG_MEM_NR1W_SYNC_INIT_EN to zero-sweep the array after reset.
module bsg_mem_nr1w_sync #(
  parameter int width_p = 32,
  parameter int els_p = 16,
  parameter int read_ports_p = 2,
  parameter int read_write_same_addr_p = 0,
  localparam int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  output logic                               ready_o,
  input  logic                               w_v_i,
  input  logic [addr_width_lp-1:0]           w_addr_i,
  input  logic [width_p-1:0]                 w_data_i,
  input  logic [width_p-1:0]                 w_mask_i,
  input  logic [read_ports_p-1:0]            r_v_i,
  input  logic [read_ports_p*addr_width_lp-1:0] r_addr_i,
  output logic [read_ports_p*width_p-1:0]    r_data_o
);

  logic [width_p-1:0] mem_q [els_p];

  logic ready_q, ready_d;
  logic w_in_range, w_en;
  logic [width_p-1:0] w_word;

  logic mem_we;
  logic [addr_width_lp-1:0] mem_waddr;
  logic [width_p-1:0] mem_wdata;

  assign w_in_range = int'(w_addr_i) < els_p;
  assign w_en = ready_q & w_v_i & w_in_range & ~reset_i;
  assign w_word = (mem_q[w_addr_i] & ~w_mask_i)
                | (w_data_i & w_mask_i);

`ifdef BSG_MEM_NR1W_SYNC_INIT_EN
  localparam logic [addr_width_lp-1:0] last_lp =
    addr_width_lp'(els_p - 1);

  logic [addr_width_lp-1:0] sweep_q;

  assign ready_d = ready_q | (sweep_q == last_lp);

  always_ff @(posedge clk_i) begin
    if (reset_i)
      sweep_q <= '0;
    else if (!ready_q)
      sweep_q <= sweep_q + addr_width_lp'(1);
  end
`else
  assign ready_d = 1'b1;
`endif

  always_comb begin
    mem_we = w_en;
    mem_waddr = w_addr_i;
    mem_wdata = w_word;
`ifdef BSG_MEM_NR1W_SYNC_INIT_EN
    // the sweep owns the write port until ready
    if (!ready_q && !reset_i) begin
      mem_we = 1'b1;
      mem_waddr = sweep_q;
      mem_wdata = '0;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (reset_i)
      ready_q <= 1'b0;
    else
      ready_q <= ready_d;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we)
      mem_q[mem_waddr] <= mem_wdata;
  end

  assign ready_o = ready_q;

  always @(posedge clk_i) begin
    if (!reset_i && ready_q && w_v_i)
      assert (w_in_range)
        else $error("bsg_mem_nr1w_sync: write addr %0d out of range",
                    w_addr_i);
  end

  for (genvar k = 0; k < read_ports_p; k++) begin : rp
    logic [addr_width_lp-1:0] addr;
    logic [width_p-1:0] rd_word, data_d, data_q;
    logic hit;

    assign addr = r_addr_i[k*addr_width_lp +: addr_width_lp];
    assign hit = w_en & (addr == w_addr_i);

    // mode 2 forwards the merged word; other modes see the old word
    always_comb begin
      rd_word = mem_q[addr];
      if (read_write_same_addr_p == 2 && hit)
        rd_word = w_word;
    end

    assign data_d = (ready_q & r_v_i[k]) ? rd_word : data_q;

    always_ff @(posedge clk_i) begin
      if (reset_i)
        data_q <= '0;
      else
        data_q <= data_d;
    end

    assign r_data_o[k*width_p +: width_p] = data_q;

    always @(posedge clk_i) begin
      if (!reset_i && ready_q && r_v_i[k]) begin
        assert (int'(addr) < els_p)
          else $error("bsg_mem_nr1w_sync: port %0d addr %0d out of range",
                      k, addr);
        assert (!(read_write_same_addr_p == 0 && hit))
          else $error("bsg_mem_nr1w_sync: port %0d r/w collision", k);
      end
    end
  end

endmodule

// File: tb/tb_bsg_mem_nr1w_sync.sv
// Bench for bsg_mem_nr1w_sync: read-old and write-first instances driven
// by shared stimulus, checked against an array model every cycle.
module tb_bsg_mem_nr1w_sync;
  localparam int W = 32;
  localparam int E = 16;
  localparam int P = 3;
  localparam int A = 4;
`ifdef BSG_MEM_NR1W_SYNC_INIT_EN
  localparam int LAT = E;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic w_v;
  logic [A-1:0] w_addr;
  logic [W-1:0] w_data, w_mask;
  logic [P-1:0] r_v;
  logic [P*A-1:0] r_addr;
  logic rdy1, rdy2;
  logic [P*W-1:0] rd1, rd2;

  bsg_mem_nr1w_sync #(
    .width_p(W), .els_p(E), .read_ports_p(P),
    .read_write_same_addr_p(1)
  ) u1 (
    .clk_i(clk), .reset_i(rst), .ready_o(rdy1),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(r_addr),
    .r_data_o(rd1)
  );

  bsg_mem_nr1w_sync #(
    .width_p(W), .els_p(E), .read_ports_p(P),
    .read_write_same_addr_p(2)
  ) u2 (
    .clk_i(clk), .reset_i(rst), .ready_o(rdy2),
    .w_v_i(w_v), .w_addr_i(w_addr), .w_data_i(w_data),
    .w_mask_i(w_mask), .r_v_i(r_v), .r_addr_i(r_addr),
    .r_data_o(rd2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // model: m index 0 = read-old instance, 1 = write-first instance
  logic [W-1:0] m_mem [E];
  bit m_known [E];
  logic [W-1:0] m_out [2][P];
  bit m_out_known [2][P];
  bit m_rdy = 0;
  bit m_rdy_known = 0;
  int m_cnt = 0;

  initial
    for (int i = 0; i < E; i++) m_known[i] = 0;
  initial
    for (int m = 0; m < 2; m++)
      for (int k = 0; k < P; k++) m_out_known[m][k] = 0;

  function automatic logic [W-1:0] port(int m, int k);
    return (m == 0) ? rd1[k*W +: W] : rd2[k*W +: W];
  endfunction

  task automatic model_edge();
    logic [W-1:0] merged;
    logic [A-1:0] a;
    bit coll;
    if (rst) begin
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < P; k++) begin
          m_out[m][k] = '0;
          m_out_known[m][k] = 1;
        end
      m_rdy = 0;
      m_rdy_known = 1;
      m_cnt = 0;
      return;
    end
    if (m_rdy) begin
      merged = (m_mem[w_addr] & ~w_mask) | (w_data & w_mask);
      for (int k = 0; k < P; k++)
        if (r_v[k]) begin
          a = r_addr[k*A +: A];
          coll = w_v && (w_addr == a);
          m_out[0][k] = m_mem[a];
          m_out_known[0][k] = m_known[a];
          m_out[1][k] = coll ? merged : m_mem[a];
          m_out_known[1][k] = m_known[a] || (coll && w_mask == '1);
        end
      if (w_v) begin
        m_mem[w_addr] = merged;
        m_known[w_addr] = m_known[w_addr] || (w_mask == '1);
      end
    end else begin
      m_cnt++;
      if (m_cnt == LAT) begin
        m_rdy = 1;
`ifdef BSG_MEM_NR1W_SYNC_INIT_EN
        for (int i = 0; i < E; i++) begin
          m_mem[i] = '0;
          m_known[i] = 1;
        end
`endif
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_rdy_known) begin
      n_cmp++;
      if (rdy1 !== m_rdy || rdy2 !== m_rdy) begin
        n_bad++;
        $display("FAIL cmp_ready: got %b/%b want %b", rdy1, rdy2, m_rdy);
      end
      for (int m = 0; m < 2; m++)
        for (int k = 0; k < P; k++)
          if (m_out_known[m][k]) begin
            n_cmp++;
            if (port(m, k) !== m_out[m][k]) begin
              n_bad++;
              $display("FAIL cmp_data mode%0d port%0d: got %h want %h",
                       m + 1, k, port(m, k), m_out[m][k]);
            end
          end
    end
  end

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    w_v = 0;
    r_v = '0;
    w_mask = '1;
  endtask

  task automatic wr(int a, logic [W-1:0] d, logic [W-1:0] msk);
    w_v = 1;
    w_addr = A'(a);
    w_data = d;
    w_mask = msk;
  endtask

  task automatic set_ra(int k, int a);
    r_addr[k*A +: A] = A'(a);
  endtask

  task automatic wait_ready(string name);
    int c;
    c = 0;
    while (!rdy1 && c < 200) begin
      cyc();
      c++;
    end
    chk(name, W'(c), W'(LAT));
  endtask

  initial begin
    rst = 1;
    idle();
    w_addr = '0;
    w_data = '0;
    r_addr = '0;
    repeat (3) cyc();
    chk("reset_ready1", W'(rdy1), '0);
    chk("reset_ready2", W'(rdy2), '0);
    for (int k = 0; k < P; k++) begin
      chk("reset_data1", port(0, k), '0);
      chk("reset_data2", port(1, k), '0);
    end
    rst = 0;
    wait_ready("ready_latency");

`ifdef BSG_MEM_NR1W_SYNC_INIT_EN
    rst = 1;
    cyc();
    rst = 0;
    repeat (8) cyc();
    rst = 1;
    cyc();
    chk("sweep_abort_ready", W'(rdy1), '0);
    rst = 0;
    wait_ready("sweep_restart_latency");
    for (int i = 0; i < E; i++) begin
      r_v = 3'b001;
      set_ra(0, i);
      cyc();
      chk("sweep_zero", port(0, 0), '0);
    end
`else
    for (int i = 0; i < E; i++) begin
      wr(i, W'($urandom), '1);
      cyc();
    end
`endif
    idle();

    wr(5, 32'hDEADBEEF, '1);
    cyc();
    idle();
    r_v = 3'b111;
    for (int k = 0; k < P; k++) set_ra(k, 5);
    cyc();
    for (int k = 0; k < P; k++) begin
      chk("basic_rd_m1", port(0, k), 32'hDEADBEEF);
      chk("basic_rd_m2", port(1, k), 32'hDEADBEEF);
    end

    idle();
    wr(3, 32'hFFFF0000, '1);
    cyc();
    wr(3, 32'h0000ABCD, 32'h0000FFFF);
    cyc();
    idle();
    r_v = 3'b010;
    set_ra(1, 3);
    cyc();
    chk("masked_rd", port(0, 1), 32'hFFFFABCD);
    r_v = '0;
    wr(3, 32'h12345678, '1);
    repeat (4) begin
      cyc();
      chk("hold_m1", port(0, 1), 32'hFFFFABCD);
      chk("hold_m2", port(1, 1), 32'hFFFFABCD);
    end

    idle();
    wr(7, 32'h11111111, '1);
    cyc();
    wr(7, 32'h22222222, '1);
    r_v = 3'b001;
    set_ra(0, 7);
    cyc();
    chk("coll_read_old", port(0, 0), 32'h11111111);
    chk("coll_write_first", port(1, 0), 32'h22222222);
    w_v = 0;
    cyc();
    chk("after_coll", port(0, 0), 32'h22222222);

    idle();
    wr(7, 32'h11111111, '1);
    cyc();
    wr(7, 32'h22222222, 32'hFF00FF00);
    r_v = 3'b101;
    set_ra(0, 7);
    set_ra(2, 7);
    cyc();
    chk("coll_mask_p0", port(1, 0), 32'h22112211);
    chk("coll_mask_p2", port(1, 2), 32'h22112211);
    chk("coll_mask_old", port(0, 2), 32'h11111111);

    idle();
    wr(2, 32'hAAAA5555, '1);
    cyc();
    wr(2, 32'h0, '1);
    r_v = 3'b111;
    rst = 1;
    cyc();
    chk("midrst_ready", W'(rdy1), '0);
    for (int k = 0; k < P; k++)
      chk("midrst_data", port(1, k), '0);
    rst = 0;
    idle();
    wait_ready("midrst_latency");
    r_v = 3'b001;
    set_ra(0, 2);
    cyc();
`ifdef BSG_MEM_NR1W_SYNC_INIT_EN
    chk("midrst_keep", port(0, 0), '0);
`else
    chk("midrst_keep", port(0, 0), 32'hAAAA5555);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      w_v = $urandom_range(0, 1) == 1;
      w_addr = A'($urandom_range(0, E - 1));
      w_data = W'($urandom);
      case ($urandom_range(0, 2))
        0: w_mask = '1;
        1: w_mask = W'($urandom);
        default: w_mask = '0;
      endcase
      r_v = P'($urandom);
      for (int k = 0; k < P; k++) set_ra(k, $urandom_range(0, E - 1));
      cyc();
    end
    rst = 0;
    idle();
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bsg_mem_nr1w_sync.md
Name: bsg_mem_nr1w_sync

Overview:
- Parametrised synchronous-read register-file memory with one write port and read_ports_p independent read ports.
- Successor to the fixed 2-read-port sync RAM; used by register files, scoreboards and multi-issue tag arrays.
- Adds:
  - a configurable read/write collision mode;
  - a per-bit write mask;
  - per-port output hold;
  - a ready_o init handshake.

Parameters:
- width_p, none (required), data word width in bits (>=1)
- els_p, none (required), number of words (>=2)
- read_ports_p, 2, number of read ports (1..8)
- read_write_same_addr_p, 0, collision mode. 0 = illegal/undefined; 1 = read-old; 2 = write-first.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p), address width (derived)

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- ready_o  out  1  memory accepts reads/writes
- w_v_i  in  1  write valid
- w_addr_i  in  addr_width_lp  write address
- w_data_i  in  width_p  write data
- w_mask_i  in  width_p  per-bit write enable; 1 = bit written
- r_v_i  in  read_ports_p  per-port read valid
- r_addr_i  in  read_ports_p*addr_width_lp  port k address at bits [k*addr_width_lp +: addr_width_lp]
- r_data_o  out  read_ports_p*width_p  port k data at bits [k*width_p +: width_p]

Behaviour:
- Clock and reset: one clock, clk_i. reset_i is synchronous and active-high.
- Reset values:
  - ready_o = 0.
  - All r_data_o = 0.
  - Memory contents are not cleared, except under the optional feature.
- ready_o: rises on the first clk_i edge after reset_i deasserts, unless the optional feature is enabled.
- While ready_o = 0:
  - w_v_i and r_v_i are ignored.
  - r_data_o holds its value.
- Write: when ready_o & w_v_i, at the clock edge mem[w_addr_i] = (mem & ~w_mask_i) | (w_data_i & w_mask_i).
- Read latency is 1 cycle:
  - If r_v_i[k] is sampled at edge t, r_data_o[k] is valid after edge t and holds until the next edge where r_v_i[k] = 1.
  - If r_v_i[k] = 0, r_data_o[k] is unchanged (hold; no X).
- Collision (read port address equals the write address, both valid in the same cycle):
  - Mode 0: r_data_o[k] is undefined. The simulation assertion fires with $error.
  - Mode 1: returns the pre-write word.
  - Mode 2: returns the merged post-write word (old bits where mask = 0, new bits where mask = 1). Forwarding is per port and independent.
- Multiple ports reading the same address in the same cycle is always legal; each port returns the same word.
- Out-of-range w_addr_i (>= els_p, possible when els_p is not a power of 2): write suppressed, $error in simulation.
- Out-of-range r_addr_i: r_data_o[k] is undefined, $error in simulation.
- Reset asserted mid-operation:
  - ready_o drops at the next edge.
  - Any write in that same cycle is dropped.
  - r_data_o returns to 0.
- Implementation is pure synthesizable flops/mux. No hard macro at this level; hardening wrappers instantiate this as the fallback.

Optional Feature:
- Macro: BSG_MEM_NR1W_SYNC_INIT_EN.
- When defined:
  - After reset_i deasserts, an internal counter sweeps addresses 0..els_p-1, writing all-zero words, one per cycle.
  - ready_o stays 0 for exactly els_p cycles after reset deassertion, then rises.
  - Reset asserted during the sweep restarts it from address 0 after deassertion.
- When undefined:
  - No sweep; contents are uninitialised (X in simulation).
  - ready_o rises 1 cycle after reset deasserts.

Test Plan:
- Basic write/read:
  - Stimulus: width_p=32, els_p=16, read_ports_p=3, mode 0. Write 0xDEADBEEF to addr 5 (mask all-ones). Next cycle, read addr 5 on ports 0, 1 and 2.
  - Required response: all three ports show 0xDEADBEEF one cycle later.
- Masked write and hold:
  - Stimulus: addr 3 holds 0xFFFF0000. Write 0x0000ABCD with mask 0x0000FFFF. Read port 1, then drop r_v_i[1] for 4 cycles while writing 0x12345678 to addr 3.
  - Required response: r_data_o[1] = 0xFFFFABCD and stays 0xFFFFABCD through the hold cycles.
- Collision mode 1:
  - Stimulus: addr 7 = 0x11111111. In the same cycle, write 0x22222222 to addr 7 and read addr 7 on port 0.
  - Required response: port 0 returns 0x11111111. A read of addr 7 on the next cycle returns 0x22222222.
- Collision mode 2 with mask:
  - Stimulus: addr 7 = 0x11111111. In the same cycle, write 0x22222222 with mask 0xFF00FF00 and read addr 7 on ports 0 and 2.
  - Required response: both ports return 0x22112211.
- Reset mid-traffic:
  - Stimulus: reset_i asserted during a write to addr 2.
  - Required response: r_data_o = 0 and ready_o = 0 the next cycle; addr 2 keeps its old value; ready_o = 1 one cycle after deassertion.
- INIT_EN sweep:
  - Stimulus: BSG_MEM_NR1W_SYNC_INIT_EN defined, els_p=16. Release reset, count cycles until ready_o = 1. Reassert reset at sweep cycle 8 and repeat.
  - Required response: ready_o = 0 for exactly 16 cycles before rising; once ready, all addresses read 0; the interrupted sweep restarts and again takes 16 cycles.
